// File: rtl/hack_bus_pkg.sv
// rtl/hack_bus_pkg.sv - shared widths, FSM state codes and helpers for the 16-bit 8-way bus
package hack_bus_pkg;

   localparam int NUM_REQ = 8;
   localparam int DATA_W  = 16;
   localparam int SEL_W   = 3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux8way16.sv
// rtl/mux8way16.sv - 16-bit 8-way mux gate
module mux8way16
   import hack_bus_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   input  logic [DATA_W-1:0] e,
   input  logic [DATA_W-1:0] f,
   input  logic [DATA_W-1:0] g,
   input  logic [DATA_W-1:0] h,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] out
);

   always_comb begin
      case (sel)
         3'd0:    out = a;
         3'd1:    out = b;
         3'd2:    out = c;
         3'd3:    out = d;
         3'd4:    out = e;
         3'd5:    out = f;
         3'd6:    out = g;
         default: out = h;
      endcase
   end

endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational rotating-priority picker: first set request at or above ptr, mod 8
module rr_pick8
   import hack_bus_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   idx,
   output logic               found
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [SEL_W-1:0]     off;

   // Rotating right by ptr puts the highest-priority requester at bit 0.
   assign dbl = {req, req} >> ptr;
   assign rot = dbl[NUM_REQ-1:0];

   always_comb begin
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
   end

   assign idx   = ptr + off;
   assign found = |req;

endmodule

// File: rtl/arb8way16.sv
// rtl/arb8way16.sv - round-robin arbiter/sequencer for the 8-way 16-bit bus; ARB8WAY16_BURST_EN adds locked bursts
module arb8way16
   import hack_bus_pkg::*;
`ifdef ARB8WAY16_BURST_EN
#(
   parameter int MAX_BURST = 4
)
`endif
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REQ-1:0]  req_valid,
`ifdef ARB8WAY16_BURST_EN
   input  logic [NUM_REQ-1:0]  req_lock,
`endif
   input  logic [DATA_W-1:0]   data0,
   input  logic [DATA_W-1:0]   data1,
   input  logic [DATA_W-1:0]   data2,
   input  logic [DATA_W-1:0]   data3,
   input  logic [DATA_W-1:0]   data4,
   input  logic [DATA_W-1:0]   data5,
   input  logic [DATA_W-1:0]   data6,
   input  logic [DATA_W-1:0]   data7,
   output logic [NUM_REQ-1:0]  req_ready,
   output logic [NUM_REQ-1:0]  grant,
   output logic [SEL_W-1:0]    sel,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   input  logic                out_ready
);

   logic [0:0]        state;
   logic [SEL_W-1:0]  ptr;
   logic [SEL_W-1:0]  pick_idx;
   logic              pick_found;
   logic [DATA_W-1:0] mux_out;
   logic              busy;
   logic              xfer;

`ifdef ARB8WAY16_BURST_EN
   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   logic [BEAT_W-1:0] beat_cnt;
   logic              extend;

   assign extend = req_lock[sel] && req_valid[sel] && (beat_cnt < BEAT_W'(MAX_BURST - 1));
`endif

   rr_pick8 u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   mux8way16 u_mux (
      .a   (data0),
      .b   (data1),
      .c   (data2),
      .d   (data3),
      .e   (data4),
      .f   (data5),
      .g   (data6),
      .h   (data7),
      .sel (sel),
      .out (mux_out)
   );

   assign busy = (state == ST_BUSY);

   // A withdrawn word must never be seen, so valid is gated by the live request bit.
   assign out_valid = busy && req_valid[sel];
   assign xfer      = out_valid && out_ready;
   assign out_data  = out_valid ? mux_out : '0;
   assign req_ready = (busy && out_ready) ? onehot(sel) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         grant <= '0;
         sel   <= '0;
         ptr   <= '0;
`ifdef ARB8WAY16_BURST_EN
         beat_cnt <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state <= ST_BUSY;
                  sel   <= pick_idx;
                  grant <= onehot(pick_idx);
               end
            end
            default: begin
               if (xfer) begin
`ifdef ARB8WAY16_BURST_EN
                  if (extend) begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end else begin
                     state    <= ST_IDLE;
                     grant    <= '0;
                     ptr      <= sel + 1'b1;
                     beat_cnt <= '0;
                  end
`else
                  state <= ST_IDLE;
                  grant <= '0;
                  ptr   <= sel + 1'b1;
`endif
               end else if (!req_valid[sel]) begin
                  // Withdrawal: release without advancing ptr.
                  state <= ST_IDLE;
                  grant <= '0;
`ifdef ARB8WAY16_BURST_EN
                  beat_cnt <= '0;
`endif
               end
            end
         endcase
      end
   end

endmodule
